// File: rtl/main_decoder_if.sv
// Instruction-class inputs and registered control outputs of the main decoder.
// The decoder sits on the slave side and the instruction source on the master side.
interface main_decoder_if;
    logic [1:0] tipo;
    logic [1:0] op;
    logic       Inm;

    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic       ALUSrc;
    logic       MemWrite;
    logic       ResultSrc;
    logic       Branch;
    logic [1:0] ALUOp;
    logic [1:0] RGB;

    modport master (
        output tipo, op, Inm,
        input  RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, RGB
    );

    modport slave (
        input  tipo, op, Inm,
        output RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, RGB
    );
endinterface

// File: rtl/main_decoder.sv
// Main control decoder: one-cycle registered decode of {tipo, op, Inm} into datapath controls.
// Free-running, no handshake: a new instruction is decoded every cycle.
module main_decoder (
    input  logic           clk,
    input  logic           rst,
    main_decoder_if.slave  bus
);
    typedef struct packed {
        logic       reg_write;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic [1:0] rgb;
    } ctrl_t;

    ctrl_t ctrl_next;
    ctrl_t ctrl_q;

    // Unknown or unlisted codes fall to the default and yield the all-zero vector.
    always_comb begin
        ctrl_next = '0;
        case ({bus.tipo, bus.op})
            4'b00_00, 4'b00_01, 4'b00_10, 4'b00_11: begin
                ctrl_next.reg_write = 1'b1;
                ctrl_next.alu_src   = bus.Inm;
                ctrl_next.imm_src   = 2'b00;
                ctrl_next.alu_op    = 2'b10;
            end
            4'b01_00, 4'b01_01, 4'b01_10, 4'b01_11: begin
                ctrl_next.reg_write  = 1'b1;
                ctrl_next.alu_src    = 1'b1;
                ctrl_next.imm_src    = 2'b01;
                ctrl_next.result_src = 1'b1;
                ctrl_next.alu_op     = 2'b00;
                ctrl_next.rgb        = bus.op;
            end
            4'b10_00, 4'b10_01, 4'b10_10, 4'b10_11: begin
                ctrl_next.imm_src = 2'b10;
                ctrl_next.branch  = 1'b1;
                ctrl_next.alu_op  = 2'b01;
            end
            4'b11_01, 4'b11_10, 4'b11_11: begin
                ctrl_next.alu_src   = 1'b1;
                ctrl_next.imm_src   = 2'b01;
                ctrl_next.mem_write = 1'b1;
                ctrl_next.alu_op    = 2'b00;
                ctrl_next.rgb       = bus.op;
            end
            // RET: redirect the PC without the compare ALU op.
            4'b11_00: begin
                ctrl_next.imm_src = 2'b10;
                ctrl_next.branch  = 1'b1;
                ctrl_next.alu_op  = 2'b00;
            end
            default: ctrl_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_next;
        end
    end

    assign bus.RegWrite  = ctrl_q.reg_write;
    assign bus.ImmSrc    = ctrl_q.imm_src;
    assign bus.ALUSrc    = ctrl_q.alu_src;
    assign bus.MemWrite  = ctrl_q.mem_write;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.Branch    = ctrl_q.branch;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.RGB       = ctrl_q.rgb;
endmodule

// File: tb/tb_main_decoder.sv
// Directed, table-driven bench for main_decoder; expected vectors are hand-computed.
// Vector layout: {RegWrite, ImmSrc[1:0], ALUSrc, MemWrite, ResultSrc, Branch, ALUOp[1:0], RGB[1:0]}.
module tb_main_decoder;
    logic clk;
    logic rst;

    main_decoder_if bus ();

    main_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string      name;
        logic [1:0] tipo;
        logic [1:0] op;
        logic       inm;
        logic [10:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] outputs_now();
        return {bus.RegWrite, bus.ImmSrc, bus.ALUSrc, bus.MemWrite,
                bus.ResultSrc, bus.Branch, bus.ALUOp, bus.RGB};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic [1:0] o, input logic i);
        bus.tipo = t;
        bus.op   = o;
        bus.Inm  = i;
    endtask

    task automatic check_exclusive(input string name);
        checks++;
        if (bus.RegWrite && bus.MemWrite) begin
            errors++;
            $display("FAIL %s: RegWrite=%b MemWrite=%b both set", name, bus.RegWrite, bus.MemWrite);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"arith_op00_inm0", 2'b00, 2'b00, 1'b0, 11'b1_00_0_0_0_0_10_00});
        vecs.push_back('{"arith_op00_inm1", 2'b00, 2'b00, 1'b1, 11'b1_00_1_0_0_0_10_00});
        vecs.push_back('{"arith_op11_inm0", 2'b00, 2'b11, 1'b0, 11'b1_00_0_0_0_0_10_00});
        vecs.push_back('{"read_ldw",        2'b01, 2'b00, 1'b0, 11'b1_01_1_0_1_0_00_00});
        vecs.push_back('{"read_ldr",        2'b01, 2'b01, 1'b1, 11'b1_01_1_0_1_0_00_01});
        vecs.push_back('{"read_ldg",        2'b01, 2'b10, 1'b0, 11'b1_01_1_0_1_0_00_10});
        vecs.push_back('{"read_ldb",        2'b01, 2'b11, 1'b1, 11'b1_01_1_0_1_0_00_11});
        vecs.push_back('{"flow_beq",        2'b10, 2'b11, 1'b0, 11'b0_10_0_0_0_1_01_00});
        vecs.push_back('{"flow_op00_inm1",  2'b10, 2'b00, 1'b1, 11'b0_10_0_0_0_1_01_00});
        vecs.push_back('{"write_str",       2'b11, 2'b01, 1'b0, 11'b0_01_1_1_0_0_00_01});
        vecs.push_back('{"write_stg",       2'b11, 2'b10, 1'b1, 11'b0_01_1_1_0_0_00_10});
        vecs.push_back('{"write_stb",       2'b11, 2'b11, 1'b0, 11'b0_01_1_1_0_0_00_11});
        vecs.push_back('{"ret",             2'b11, 2'b00, 1'b0, 11'b0_10_0_0_0_1_00_00});
        vecs.push_back('{"ret_inm1",        2'b11, 2'b00, 1'b1, 11'b0_10_0_0_0_1_00_00});

        // Reset held across clock edges with a live instruction present.
        rst = 1'b1;
        drive(2'b00, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", outputs_now(), 11'b0);

        // First post-reset edge loads the decode present at that edge.
        @(negedge clk);
        rst = 1'b0;
        drive(2'b01, 2'b10, 1'b0);
        @(posedge clk);
        #1 check("first_after_reset", outputs_now(), 11'b1_01_1_0_1_0_00_10);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].tipo, vecs[k].op, vecs[k].inm);
            @(posedge clk);
            #1;
            check(vecs[k].name, outputs_now(), vecs[k].exp);
            check_exclusive({vecs[k].name, "_excl"});
        end

        // Latency: a mid-cycle input change must not reach the outputs before the next edge.
        @(negedge clk);
        drive(2'b11, 2'b01, 1'b0);
        @(posedge clk);
        #1 check("lat_a_loaded", outputs_now(), 11'b0_01_1_1_0_0_00_01);
        #2 drive(2'b00, 2'b10, 1'b1);
        #1 check("lat_hold_before_edge", outputs_now(), 11'b0_01_1_1_0_0_00_01);
        @(posedge clk);
        #1 check("lat_b_one_cycle", outputs_now(), 11'b1_00_1_0_0_0_10_00);

        // Mid-cycle reset: outputs clear immediately and the pending decode is discarded.
        #2 rst = 1'b1;
        #1 check("async_reset_immediate", outputs_now(), 11'b0);
        drive(2'b10, 2'b01, 1'b0);
        @(posedge clk);
        #1 check("reset_ignores_edge", outputs_now(), 11'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_release_no_edge", outputs_now(), 11'b0);
        @(posedge clk);
        #1 check("decode_after_release", outputs_now(), 11'b0_10_0_0_0_1_01_00);

        // Back-to-back instructions, one per cycle.
        @(negedge clk);
        drive(2'b01, 2'b11, 1'b1);
        @(posedge clk);
        #1 check("b2b_first", outputs_now(), 11'b1_01_1_0_1_0_00_11);
        @(negedge clk);
        drive(2'b11, 2'b00, 1'b0);
        @(posedge clk);
        #1 check("b2b_second", outputs_now(), 11'b0_10_0_0_0_1_00_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past 100000 time units, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/main_decoder.md
MAIN_DECODER -- requirements
Module: main_decoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all output registers.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 tipo  input  2  instruction class: 00 arithmetic, 01 read, 10 flow, 11 write.
REQ-006 op  input  2  operation within class; selects the colour channel for read/write.
REQ-007 Inm  input  1  immediate-operand flag.
REQ-008 RegWrite  output  1  register-file write enable.
REQ-009 ImmSrc  output  2  immediate format: 00 ALU immediate, 01 memory offset, 10 branch target.
REQ-010 ALUSrc  output  1  1 = ALU operand B is the immediate; 0 = operand B is a register.
REQ-011 MemWrite  output  1  data-memory write enable.
REQ-012 ResultSrc  output  1  1 = write-back from memory; 0 = write-back from ALU.
REQ-013 Branch  output  1  PC-redirect request.
REQ-014 ALUOp  output  2  ALU class code: 00 add (address), 01 subtract (compare), 10 decode by op.
REQ-015 RGB  output  2  channel select: 00 none/full word, 01 red, 10 green, 11 blue.

Function
REQ-016 All outputs SHALL be registered and SHALL be updated on each rising clk edge from the tipo/op/Inm values sampled at that edge.
REQ-017 Latency SHALL be exactly one cycle, with no handshake; a new instruction is accepted every cycle.
REQ-018 For tipo=00 (arithmetic, any op) the outputs SHALL be:
- RegWrite=1, ALUSrc=Inm, ImmSrc=00
- MemWrite=0, ResultSrc=0, Branch=0
- ALUOp=10, RGB=00
REQ-019 For tipo=01 (read: op 00 LDW, 01 LDR, 10 LDG, 11 LDB) the outputs SHALL be:
- RegWrite=1, ALUSrc=1, ImmSrc=01
- MemWrite=0, ResultSrc=1, Branch=0
- ALUOp=00, RGB=op
- Inm SHALL be ignored.
REQ-020 For tipo=10 (flow, any op, including 11 BEQ) the outputs SHALL be:
- RegWrite=0, ALUSrc=0, ImmSrc=10
- MemWrite=0, ResultSrc=0, Branch=1
- ALUOp=01, RGB=00
- The condition is evaluated outside this block.
REQ-021 For tipo=11 with op≠00 (write: 01 STR, 10 STG, 11 STB) the outputs SHALL be:
- RegWrite=0, ALUSrc=1, ImmSrc=01
- MemWrite=1, ResultSrc=0, Branch=0
- ALUOp=00, RGB=op
- Inm SHALL be ignored.
REQ-022 For tipo=11 with op=00 (RET) the outputs SHALL be:
- RegWrite=0, ALUSrc=0, ImmSrc=10
- MemWrite=0, ResultSrc=0, Branch=1
- ALUOp=00, RGB=00
REQ-023 MemWrite and RegWrite SHALL never both be 1 in the same cycle.
REQ-024 Any X/Z on tipo or op SHALL produce the all-zero output vector.
REQ-025 The decode SHALL be a single full case over {tipo, op}; there SHALL be no internal state beyond the output registers.

Reset
REQ-026 Asserting rst SHALL immediately, without waiting for clk, force all outputs to 0: RegWrite, ImmSrc=00, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp=00, RGB=00.
REQ-027 While rst=1, outputs SHALL hold 0 regardless of clk and inputs.
REQ-028 The first rising clk edge after rst deasserts SHALL load the decode of the inputs present at that edge.
REQ-029 rst asserted mid-stream SHALL discard the pending decode; outputs SHALL be 0 until the next post-reset edge.

Verification
REQ-030 Apply tipo=00, op=00, Inm=0, one clk -> RegWrite=1, ALUSrc=0, ALUOp=10, Branch=0, MemWrite=0, ResultSrc=0, RGB=00; repeat with Inm=1 -> ALUSrc=1.
REQ-031 Apply tipo=01, op=01/10/11 (Inm alternating 1/0/1) -> RegWrite=1, ALUSrc=1, ALUOp=00, ResultSrc=1, MemWrite=0, Branch=0, RGB=01/10/11.
REQ-032 Apply tipo=10, op=11, Inm=0 -> Branch=1, RegWrite=0, ALUSrc=0, ALUOp=01, ImmSrc=10, MemWrite=0, RGB=00.
REQ-033 Apply tipo=11, op=01/10/11 -> MemWrite=1, RegWrite=0, ALUSrc=1, ResultSrc=0, RGB=01/10/11; then tipo=11, op=00 -> Branch=1, MemWrite=0, RegWrite=0, RGB=00.
REQ-034 Check latency: change inputs between clk edges -> outputs change only at the next rising edge, exactly one cycle later.
REQ-035 Assert rst between edges while outputs are non-zero -> all outputs 0 immediately; deassert rst -> correct decode after the next rising edge.
